// File: rtl/lzd_pkg.sv
// Shared helpers for the leading-zero normalizer: count width and zero-flag derivation.
package lzd_pkg;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic zero_flag(input logic any_one);
    return !any_one;
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter: cnt = DATA_WIDTH when no bit is set.
module lzc_tree
  import lzd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int CNT_WIDTH = cnt_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic                  any_one
);

  // Scanning upward lets the highest set bit win, which gives the leading-zero count.
  always_comb begin
    cnt     = CNT_WIDTH'(DATA_WIDTH);
    any_one = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (data[i]) begin
        cnt     = CNT_WIDTH'(DATA_WIDTH - 1 - i);
        any_one = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lzd_normalizer.sv
// Two-stage leading-bit normalizer with valid/ready handshake on both sides.
// Define LZD_NORM_SIGNED_EN to normalize two's-complement words instead of unsigned.
module lzd_normalizer
  import lzd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int CNT_WIDTH = cnt_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic                  out_zero
);

  logic                  s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [CNT_WIDTH-1:0]  s1_cnt;
  logic                  s1_zero;
  logic                  s1_adv, s2_adv;

  logic [DATA_WIDTH-1:0] lzc_in;
  logic [CNT_WIDTH-1:0]  lzc_cnt;
  logic                  lzc_any;
  logic [CNT_WIDTH-1:0]  norm_cnt;

`ifdef LZD_NORM_SIGNED_EN
  // Sign-redundancy bits become zeros; bit MSB of lzc_in is always 0, so lzc_cnt >= 1.
  assign lzc_in   = in_data ^ {in_data[DATA_WIDTH-1], in_data[DATA_WIDTH-1:1]};
  assign norm_cnt = lzc_cnt - CNT_WIDTH'(1);
`else
  assign lzc_in   = in_data;
  assign norm_cnt = lzc_cnt;
`endif

  lzc_tree #(.DATA_WIDTH(DATA_WIDTH)) u_lzc (
    .data    (lzc_in),
    .cnt     (lzc_cnt),
    .any_one (lzc_any)
  );

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic [DATA_WIDTH-1:0] stage [0:CNT_WIDTH];
  assign stage[0] = s1_data;

  for (genvar k = 0; k < CNT_WIDTH; k++) begin : g_shift
    assign stage[k+1] = s1_cnt[k] ? (stage[k] << (2 ** k)) : stage[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data  <= '0;
      s1_cnt   <= '0;
      s1_zero  <= 1'b0;
      out_data <= '0;
      out_cnt  <= '0;
      out_zero <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_cnt  <= norm_cnt;
          s1_zero <= zero_flag(lzc_any);
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= stage[CNT_WIDTH];
          out_cnt  <= s1_cnt;
          out_zero <= s1_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_lzd_normalizer.sv
// Directed self-checking bench for lzd_normalizer (32-bit and 24-bit instances).
module tb_lzd_normalizer;

`ifdef LZD_NORM_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_data, out_data;
  logic [5:0]  out_cnt;

  logic        in_valid24, in_ready24, out_valid24, out_zero24;
  logic [23:0] in_data24, out_data24;
  logic [4:0]  out_cnt24;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lzd_normalizer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cnt(out_cnt), .out_zero(out_zero)
  );

  lzd_normalizer #(.DATA_WIDTH(24)) dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid24), .in_ready(in_ready24), .in_data(in_data24),
    .out_valid(out_valid24), .out_ready(1'b1), .out_data(out_data24),
    .out_cnt(out_cnt24), .out_zero(out_zero24)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] din, input logic [31:0] e_data,
                         input logic [5:0] e_cnt, input logic e_zero);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = din;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    chk({tag, "_lat1_valid"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, e_data);
    chk({tag, "_cnt"}, out_cnt, e_cnt);
    chk({tag, "_zero"}, out_zero, e_zero);
    tick();
  endtask

  logic [31:0] s_word [10] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0070, 32'h0001_2345,
                               32'h4000_0000, 32'h0000_00FF, 32'h0BAD_F00D, 32'h0000_0000,
                               32'h0000_1000, 32'h0000_0009};
  logic [31:0] u_data [10] = '{32'hC000_0000, 32'hA000_0000, 32'hE000_0000, 32'h91A2_8000,
                               32'h8000_0000, 32'hFF00_0000, 32'hBADF_00D0, 32'h0000_0000,
                               32'h8000_0000, 32'h9000_0000};
  logic [5:0]  u_cnt  [10] = '{6'd30, 6'd29, 6'd25, 6'd15, 6'd1, 6'd24, 6'd4, 6'd32, 6'd19, 6'd28};
  logic [31:0] e_data [10];
  logic [5:0]  e_cnt  [10];
  logic        e_zero [10];

  initial begin
    int  idx;
    int  k;
    bit  in_hs;

    // Signed expectations for these non-negative words: one less shift, MSB stays 0.
    for (int i = 0; i < 10; i++) begin
      e_zero[i] = (s_word[i] == 32'h0);
      if (!SGN)            begin e_data[i] = u_data[i];        e_cnt[i] = u_cnt[i];        end
      else if (e_zero[i])  begin e_data[i] = 32'h0;            e_cnt[i] = 6'd31;           end
      else                 begin e_data[i] = u_data[i] >> 1;   e_cnt[i] = u_cnt[i] - 6'd1; end
    end

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid24 = 1'b0; in_data24 = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid24", out_valid24, 0);

    run_one("one", 32'h0000_0001, SGN ? 32'h4000_0000 : 32'h8000_0000, SGN ? 6'd30 : 6'd31, 1'b0);
    run_one("zero", 32'h0000_0000, 32'h0, SGN ? 6'd31 : 6'd32, 1'b1);
    run_one("msb", 32'h8000_0000, 32'h8000_0000, 6'd0, 1'b0);
    run_one("mid", 32'h00F0_0000, SGN ? 32'h7800_0000 : 32'hF000_0000, SGN ? 6'd7 : 6'd8, 1'b0);
`ifdef LZD_NORM_SIGNED_EN
    run_one("neg", 32'hFFFF_FFF0, 32'h8000_0000, 6'd27, 1'b0);
    run_one("all_ones", 32'hFFFF_FFFF, 32'h8000_0000, 6'd31, 1'b1);
`endif

    in_valid24 = 1'b1;
    in_data24  = 24'h00_8000;
    tick();
    in_valid24 = 1'b0;
    tick();
    chk("w24_valid", out_valid24, 1);
    chk("w24_data", out_data24, SGN ? 24'h40_0000 : 24'h80_0000);
    chk("w24_cnt", out_cnt24, SGN ? 5'd7 : 5'd8);
    chk("w24_zero", out_zero24, 0);
    tick();

    idx = 0;
    k   = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (idx < 10);
      in_data   = (idx < 10) ? s_word[idx] : 32'h0;
      #1;
      if (c == 3 || c == 6) chk("stall_in_ready", in_ready, 0);
      if (c == 7) chk("resume_in_ready", in_ready, 1);
      if (out_valid) begin
        if (k < 10) begin
          chk($sformatf("stream%0d_data", k), out_data, e_data[k]);
          chk($sformatf("stream%0d_cnt", k), out_cnt, e_cnt[k]);
          chk($sformatf("stream%0d_zero", k), out_zero, e_zero[k]);
          if (out_ready) k++;
        end else begin
          chk("stream_extra_word", out_valid, 0);
        end
      end
      in_hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (in_hs) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_accepted", idx, 10);
    chk("stream_emitted", k, 10);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0011;
    tick();
    in_data   = 32'h0000_0022;
    tick();
    chk("flight_out_valid", out_valid, 1);
    chk("flight_in_ready", in_ready, 0);
    rst      = 1'b1;
    in_data  = 32'h0000_00FF;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_ghost", out_valid, 0);
    end
    run_one("post_rst", 32'h00F0_0000, SGN ? 32'h7800_0000 : 32'hF000_0000, SGN ? 6'd7 : 6'd8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lzd_normalizer.md
LZD_NORMALIZER -- requirements
Module: lzd_normalizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, input word width (>=2, any value, not only powers of 2).
REQ-002 SHALL have localparam CNT_WIDTH = $clog2(DATA_WIDTH+1), count width able to represent DATA_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream word valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  word to normalize.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  normalized word.
REQ-011 SHALL have port out_cnt  output  CNT_WIDTH  leading-bit count (shift amount applied).
REQ-012 SHALL have port out_zero  output  1  input had no significant bit.

Function
REQ-013 SHALL transfer input when in_valid && in_ready; output when out_valid && out_ready.
REQ-014 SHALL be a 2-stage pipeline: S1 registers word and count; S2 registers shifted word, count, zero flag.
REQ-015 SHALL produce out_valid 2 cycles after an accepted input when unstalled; throughput 1 word/cycle.
REQ-016 SHALL advance S2 when !s2_valid || out_ready; advance S1 when !s1_valid || S2 advances.
REQ-017 SHALL drive in_ready = !s1_valid || S2 advances (combinational from out_ready allowed, no loop to in_valid).
REQ-018 SHALL hold out_data/out_cnt/out_zero stable while out_valid && !out_ready.
REQ-019 SHALL never drop or duplicate words; order preserved; max 2 words in flight.
REQ-020 SHALL, unsigned mode: out_cnt = leading zeros of in_data; out_data = in_data << out_cnt, zero-filled.
REQ-021 SHALL, for in_data==0: out_cnt = DATA_WIDTH, out_zero=1, out_data=0.
REQ-022 SHALL set out_zero=0 for every non-zero input (signed mode: see REQ-028).
REQ-023 SHALL handle simultaneous accept and emit in one cycle with full throughput.

Reset
REQ-024 SHALL on rst clear s1_valid, s2_valid: out_valid=0; in_ready=1 the cycle after rst deasserts.
REQ-025 SHALL reset out_data=0, out_cnt=0, out_zero=0.
REQ-026 SHALL discard in-flight words when rst asserts mid-operation; no output from them afterwards.
REQ-027 SHALL ignore in_valid while rst=1.

Configuration
REQ-028 SHALL, with macro LZD_NORM_SIGNED_EN defined, treat in_data as two's complement: out_cnt = (count of leading bits equal to MSB) - 1; out_data = in_data << out_cnt (sign bit kept at MSB); out_zero=1 for 0 and all-ones, with out_cnt=DATA_WIDTH-1.
REQ-029 SHALL, without LZD_NORM_SIGNED_EN, implement unsigned behaviour only (REQ-020/021), with no signed logic.

Structure
REQ-030 SHALL place CNT_WIDTH computation function and a zero-flag helper in shared package lzd_pkg.
REQ-031 SHALL use one combinational sub-module lzc_tree (parametrised DATA_WIDTH, outputs count and any-one flag) in S1; signed mode feeds it in_data XOR (in_data>>1 sign-extended) form.
REQ-032 SHALL implement the shift in S2 as a log2 barrel shifter.

Verification
REQ-033 SHALL cover: W=32, in=0x0000_0001 -> out_cnt=31, out_data=0x8000_0000, out_zero=0, out_valid 2 cycles later.
REQ-034 SHALL cover: W=32, in=0x0000_0000 -> out_cnt=32, out_data=0, out_zero=1; W=24, in=0x00_8000 -> out_cnt=8, out_data=0x80_0000.
REQ-035 SHALL cover: 10 back-to-back words, out_ready low cycles 3-6 -> in_ready low after 2 stored, all 10 out in order, outputs stable while stalled.
REQ-036 SHALL cover: rst high 1 cycle with 2 words in flight -> out_valid=0 next cycle, those words never emitted, next accepted word correct.
REQ-037 SHALL cover (LZD_NORM_SIGNED_EN): W=32, in=0xFFFF_FFF0 -> out_cnt=27, out_data=0x8000_0000; in=0xFFFF_FFFF -> out_zero=1, out_cnt=31.
